// File: rtl/shift_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_pkg
// Brief    : Opcode/funct constants shared by the shift issue stage.
// Revision : 1.0
// ============================================================================
package shift_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : shift_issue_pkg
`default_nettype wire

// File: rtl/shift_issue_stage_decode.sv
`default_nettype none
// ============================================================================
// Module   : shift_decode
// Brief    : Combinational recogniser for the six R-type shift instructions.
// Revision : 1.0
// ============================================================================
module shift_decode
    import shift_issue_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_shift,
    output logic        right,
    output logic        arith,
    output logic        variable
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_funct_ok;

    assign w_op    = inst[31:26];
    assign w_funct = inst[5:0];

    always_comb begin
        w_funct_ok = 1'b0;
        case (w_funct)
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: w_funct_ok = 1'b1;
            default:                                     w_funct_ok = 1'b0;
        endcase
    end

    // The all-zero word encodes sll $0,$0,0 but is the canonical nop.
    assign is_shift = (w_op == OP_RTYPE) && w_funct_ok && (inst != 32'h0);
    assign right    = w_funct[1];
    assign arith    = w_funct[1] & w_funct[0];
    assign variable = w_funct[2];

endmodule : shift_decode
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue_stage
// Brief    : Decode/issue register feeding the barrel shifter, with bypass,
//            valid/ready handshake, flush and a saturating issue counter.
// Revision : 1.0
// ============================================================================
module shift_issue_stage
    import shift_issue_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             fwd_en,
    input  logic [4:0]       fwd_reg,
    input  logic [31:0]      fwd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      d,
    output logic [31:0]      sa,
    output logic             right,
    output logic             arith,
    output logic [4:0]       wreg,
    output logic [CNT_W-1:0] shift_cnt
);

    logic             w_is_shift;
    logic             w_right;
    logic             w_arith;
    logic             w_variable;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [31:0]      w_rs_src;
    logic [31:0]      w_rt_src;
    logic [31:0]      w_sa;
    logic             w_accept;
    logic             w_load;
    logic [26:0]      w_unused_rs_hi;

    logic             r_out_valid;
    logic [31:0]      r_d;
    logic [31:0]      r_sa;
    logic             r_right;
    logic             r_arith;
    logic [4:0]       r_wreg;
    logic [CNT_W-1:0] r_cnt;

    shift_decode u_decode (
        .inst     (inst),
        .is_shift (w_is_shift),
        .right    (w_right),
        .arith    (w_arith),
        .variable (w_variable)
    );

    function automatic logic [31:0] source(
        input logic [4:0]  r,
        input logic [31:0] rf
    );
        if (r == REG_ZERO)
            return 32'h0;
        else if (fwd_en && (fwd_reg == r))
            return fwd_data;
        else
            return rf;
    endfunction

    assign w_rs     = inst[25:21];
    assign w_rt     = inst[20:16];
    assign w_rs_src = source(w_rs, rs_val);
    assign w_rt_src = source(w_rt, rt_val);
    assign w_sa     = w_variable ? {27'b0, w_rs_src[4:0]} : {27'b0, inst[10:6]};

    // Only the low five bits of a variable shift amount matter.
    assign w_unused_rs_hi = w_rs_src[31:5];

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_is_shift && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_d         <= 32'h0;
            r_sa        <= 32'h0;
            r_right     <= 1'b0;
            r_arith     <= 1'b0;
            r_wreg      <= 5'd0;
            r_cnt       <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_d         <= w_rt_src;
                r_sa        <= w_sa;
                r_right     <= w_right;
                r_arith     <= w_arith;
                r_wreg      <= inst[15:11];
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_load && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign sa        = r_sa;
    assign right     = r_right;
    assign arith     = r_arith;
    assign wreg      = r_wreg;
    assign shift_cnt = r_cnt;

endmodule : shift_issue_stage
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_issue_stage
// Brief    : Scoreboard bench for shift_issue_stage (CNT_W=16 and CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_right, a_arith;
    logic [31:0] a_d, a_sa;
    logic [4:0]  a_wreg;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_right, b_arith;
    logic [31:0] b_d, b_sa;
    logic [4:0]  b_wreg;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    shift_issue_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst(inst), .rs_val(rs_val), .rt_val(rt_val), .fwd_en(fwd_en),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .d(a_d), .sa(a_sa),
        .right(a_right), .arith(a_arith), .wreg(a_wreg), .shift_cnt(a_cnt)
    );

    shift_issue_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .inst(inst), .rs_val(rs_val), .rt_val(rt_val), .fwd_en(fwd_en),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .d(b_d), .sa(b_sa),
        .right(b_right), .arith(b_arith), .wreg(b_wreg), .shift_cnt(b_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] sa;
        logic        right;
        logic        arith;
        logic [4:0]  wreg;
    } op_t;

    op_t exp_q[$];
    int  m_cnt16 = 0;
    int  m_cnt2  = 0;
    int  n_pass  = 0;
    int  n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] src(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'h0;
        if (fwd_en && fwd_reg == r) return fwd_data;
        return rf;
    endfunction

    // Reference: MIPS shift semantics by mnemonic.
    function automatic bit predict(output op_t o);
        bit          is_right, is_arith, is_var;
        logic [31:0] amt;
        o = '{default: '0};
        if (inst[31:26] != 6'd0 || inst == 32'h0) return 1'b0;
        case (inst[5:0])
            6'h00: {is_right, is_arith, is_var} = 3'b000; // sll
            6'h02: {is_right, is_arith, is_var} = 3'b100; // srl
            6'h03: {is_right, is_arith, is_var} = 3'b110; // sra
            6'h04: {is_right, is_arith, is_var} = 3'b001; // sllv
            6'h06: {is_right, is_arith, is_var} = 3'b101; // srlv
            6'h07: {is_right, is_arith, is_var} = 3'b111; // srav
            default: return 1'b0;
        endcase
        amt     = src(inst[25:21], rs_val);
        o.d     = src(inst[20:16], rt_val);
        o.sa    = is_var ? (amt % 32) : 32'(inst[10:6]);
        o.right = is_right;
        o.arith = is_arith;
        o.wreg  = inst[15:11];
        return 1'b1;
    endfunction

    // One clock: inputs already applied; update the model after the edge.
    task automatic cyc();
        op_t o;
        bit  held, rdy, sh, acc, c_rst, c_flush;
        held    = exp_q.size() != 0;
        rdy     = !held || out_ready;
        sh      = predict(o);
        acc     = in_valid && rdy;
        c_rst   = rst;
        c_flush = flush;
        @(posedge clk);
        #2;
        if (c_rst) begin
            exp_q.delete();
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (c_flush) begin
            exp_q.delete();
        end else if (acc && sh) begin
            exp_q.push_back(o);
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", 32'(a_out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(a_in_ready), 32'((exp_q.size() == 0) || out_ready));
        if (exp_q.size() != 0 && a_out_valid) begin
            chk("d", a_d, exp_q[0].d);
            chk("sa", a_sa, exp_q[0].sa);
            chk("right", 32'(a_right), 32'(exp_q[0].right));
            chk("arith", 32'(a_arith), 32'(exp_q[0].arith));
            chk("wreg", 32'(a_wreg), 32'(exp_q[0].wreg));
            chk("small_sa", b_sa, exp_q[0].sa);
        end
        chk("shift_cnt16", 32'(a_cnt), 32'(m_cnt16));
        chk("shift_cnt2", 32'(b_cnt), 32'(m_cnt2));
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(a_out_valid), 32'h0);
        chk({tag, "_d"}, a_d, 32'h0);
        chk({tag, "_sa"}, a_sa, 32'h0);
        chk({tag, "_right"}, 32'(a_right), 32'h0);
        chk({tag, "_arith"}, 32'(a_arith), 32'h0);
        chk({tag, "_wreg"}, 32'(a_wreg), 32'h0);
        chk({tag, "_cnt"}, 32'(a_cnt), 32'h0);
        chk({tag, "_cnt2"}, 32'(b_cnt), 32'h0);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; inst = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
        fwd_en = 1'b0; fwd_reg = 5'd0; fwd_data = 32'h0; flush = 1'b0;
    endtask

    int exp_seq[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        idle_inputs();
        cyc(); cyc();
        check_zero("reset");
        rst = 1'b0;

        // sra $9, $3, 4 with a negative operand
        in_valid = 1'b1; inst = rtype(5'd0, 5'd3, 5'd9, 5'd4, 6'h03); rt_val = 32'h8000_0000;
        cyc();
        idle_inputs(); cyc();

        // srlv from register file, then from the bypass path
        in_valid = 1'b1; inst = rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h06);
        rs_val = 32'h0000_0025; rt_val = 32'h1234_5678;
        cyc();
        fwd_en = 1'b1; fwd_reg = 5'd4; fwd_data = 32'h3;
        cyc();
        idle_inputs(); cyc();

        // sll of $0, then nop and addu
        in_valid = 1'b1; inst = rtype(5'd0, 5'd0, 5'd2, 5'd7, 6'h00); rt_val = 32'hFFFF_FFFF;
        cyc();
        inst = 32'h0; cyc();
        inst = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); cyc();
        idle_inputs(); cyc();

        // Stall: A held for three cycles while B waits, then B follows with no gap
        out_ready = 1'b0;
        in_valid = 1'b1; inst = rtype(5'd0, 5'd7, 5'd10, 5'd1, 6'h02); rt_val = 32'hAAAA_0000;
        cyc();
        inst = rtype(5'd0, 5'd8, 5'd11, 5'd31, 6'h00); rt_val = 32'h0000_0001;
        cyc(); cyc(); cyc();
        out_ready = 1'b1;
        cyc();
        idle_inputs(); cyc();

        // Flush coincident with an accepted shift
        in_valid = 1'b1; flush = 1'b1; inst = rtype(5'd0, 5'd3, 5'd4, 5'd2, 6'h03); rt_val = 32'h8;
        cyc();
        idle_inputs(); cyc();

        // Reset while an operation is held
        out_ready = 1'b0;
        in_valid = 1'b1; inst = rtype(5'd2, 5'd3, 5'd12, 5'd0, 6'h07);
        rs_val = 32'h1F; rt_val = 32'hDEAD_BEEF;
        cyc();
        idle_inputs(); rst = 1'b1;
        cyc();
        check_zero("midreset");
        rst = 1'b0; out_ready = 1'b1;

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; inst = rtype(5'd0, 5'd1, 5'd1, 5'(i), 6'h00); rt_val = 32'(i);
            cyc();
            chk("cnt2_seq", 32'(b_cnt), 32'(exp_seq[i]));
        end
        idle_inputs(); cyc();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [5:0] fn;
            logic [5:0] shfn[6] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
            r  = $urandom_range(0, 19);
            fn = shfn[$urandom_range(0, 5)];
            if (r >= 15 && r < 17) fn = 6'($urandom);
            inst = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom), 5'($urandom), fn);
            if (r == 17) inst[31:26] = 6'($urandom_range(1, 63));
            if (r == 18) inst = 32'h0;
            if (r == 19) inst = $urandom;
            rs_val    = $urandom;
            rt_val    = $urandom;
            fwd_en    = ($urandom_range(0, 1) == 1);
            fwd_reg   = 5'($urandom_range(0, 7));
            fwd_data  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; idle_inputs(); out_ready = 1'b1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_issue_stage
`default_nettype wire
